// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned INSTR_BYTES = 4;
   localparam int unsigned INSTR_W     = 32;
   localparam int unsigned PC_W_MAX    = 32;
   localparam int unsigned STAT_W      = 32;

   typedef struct packed {
      logic [PC_W_MAX-1:0] pc;
      logic [INSTR_W-1:0]  instr;
   } fetch_entry_t;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

   // Saturating add for event counters.
   function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                 input logic [STAT_W-1:0] b);
      logic [STAT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries; flush beats push in the same cycle.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  fetch_entry_t               din,
   input  logic                       pop,
   input  logic                       flush,
   output fetch_entry_t               head_c,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign head_c = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, 1-cycle imem request, {pc,instr} FIFO toward decode.
// Optional FETCH_STATS_EN adds saturating fetched/flushed counters.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH = 32,
   parameter int unsigned            DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [31:0]           imem_rdata,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_instr,
   output logic [ADDR_WIDTH-1:0] out_pc
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]           stat_fetched,
   output logic [31:0]           stat_flushed
`endif
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned SUM_W = CNT_W + 1;

   fetch_state_t          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] tag_q;
   logic                  inflight_q;
   logic                  drop_q;
   fetch_entry_t          hold_q;
   fetch_entry_t          head_c;
   fetch_entry_t          head_sel_c;
   fetch_entry_t          push_entry_c;
   logic [CNT_W-1:0]      count;
   logic                  issue_c;
   logic                  push_c;
   logic                  pop_c;

   // Next state and issue decision; a same-cycle pop does not free a slot.
   always_comb begin
      state_d = state_q;
      issue_c = 1'b0;
      case (state_q)
         BOOT: state_d = RUN;
         RUN:  issue_c = !redirect_valid &&
                         ((SUM_W'(count) + SUM_W'(inflight_q)) < SUM_W'(DEPTH));
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         tag_q      <= '0;
         inflight_q <= 1'b0;
         drop_q     <= 1'b0;
         hold_q     <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= issue_c;
         drop_q     <= redirect_valid;
         if (issue_c) tag_q <= pc_q;
         if (redirect_valid)
            pc_q <= redirect_pc & ~ADDR_WIDTH'(3);
         else if (issue_c)
            pc_q <= pc_q + ADDR_WIDTH'(INSTR_BYTES);
         if (out_valid) hold_q <= head_c;
      end
   end

   assign push_c       = inflight_q && !drop_q;
   assign pop_c        = out_valid && out_ready;
   assign push_entry_c = '{pc: PC_W_MAX'(tag_q), instr: imem_rdata};

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push   (push_c),
      .din    (push_entry_c),
      .pop    (pop_c),
      .flush  (redirect_valid),
      .head_c (head_c),
      .count  (count)
   );

   // Empty FIFO keeps showing the last head seen by decode.
   assign out_valid  = (count != '0);
   assign head_sel_c = out_valid ? head_c : hold_q;
   assign out_instr  = head_sel_c.instr;
   assign out_pc     = ADDR_WIDTH'(head_sel_c.pc);
   assign imem_req   = issue_c;
   assign imem_addr  = pc_q;

`ifdef FETCH_STATS_EN
   logic [STAT_W-1:0] flush_cnt_c;

   // Discarded on redirect: buffered entries not popped this cycle plus the arriving response.
   assign flush_cnt_c = STAT_W'(count) - STAT_W'(pop_c) + STAT_W'(push_c);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_fetched <= '0;
         stat_flushed <= '0;
      end else if (redirect_valid) begin
         stat_flushed <= sat_add(stat_flushed, flush_cnt_c);
      end else if (push_c) begin
         stat_fetched <= sat_add(stat_fetched, STAT_W'(1));
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed test of fetch_unit: streaming, back-pressure, redirect, wrap, async reset.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   logic        w_req;
   logic [7:0]  w_addr;
   logic [31:0] w_rdata = '0;
   logic        w_valid;
   logic [31:0] w_instr;
   logic [7:0]  w_pc;

`ifdef FETCH_STATS_EN
   logic [31:0] stat_fetched, stat_flushed;
   logic [31:0] w_fetched, w_flushed;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fetch_unit u_dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
`ifdef FETCH_STATS_EN
      ,
      .stat_fetched   (stat_fetched),
      .stat_flushed   (stat_flushed)
`endif
   );

   fetch_unit #(.ADDR_WIDTH(8), .DEPTH(4), .RESET_PC(8'hF8)) u_w8 (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (w_req),
      .imem_addr      (w_addr),
      .imem_rdata     (w_rdata),
      .redirect_valid (1'b0),
      .redirect_pc    (8'h00),
      .out_valid      (w_valid),
      .out_ready      (1'b1),
      .out_instr      (w_instr),
      .out_pc         (w_pc)
`ifdef FETCH_STATS_EN
      ,
      .stat_fetched   (w_fetched),
      .stat_flushed   (w_flushed)
`endif
   );

   // Synchronous instruction memories, word = tag | byte address.
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= 32'h1000_0000 | imem_addr;
      if (w_req)    w_rdata    <= 32'h2000_0000 | {24'h0, w_addr};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Hold reset two cycles, release on a falling edge.
   task automatic do_reset(input logic rdy);
      rst            = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = rdy;
      tick();
      tick();
      rst = 1'b1;
      #1;
   endtask

   initial begin
      // 1 + 5: streaming with no bubbles, and 8-bit address wrap
      do_reset(1'b1);
      check("t1_boot_req",   32'(imem_req),  32'h0);
      check("t1_boot_valid", 32'(out_valid), 32'h0);
      check("t1_boot_pc",    out_pc,         32'h0);
      check("t1_boot_instr", out_instr,      32'h0);
      check("t5_boot_req",   32'(w_req),     32'h0);
      tick();
      check("t1_req_c2",  32'(imem_req), 32'h1);
      check("t1_addr0",   imem_addr,     32'h0);
      check("t5_addr_f8", 32'(w_addr),   32'hF8);
      tick();
      check("t1_addr4",     imem_addr,     32'h4);
      check("t1_lat_valid", 32'(out_valid), 32'h0);
      check("t5_addr_fc",   32'(w_addr),   32'hFC);
      tick();
      check("t1_valid",    32'(out_valid), 32'h1);
      check("t1_pc0",      out_pc,         32'h0);
      check("t1_instr0",   out_instr,      32'h1000_0000);
      check("t1_addr8",    imem_addr,      32'h8);
      check("t5_addr_00",  32'(w_addr),    32'h00);
      check("t5_pc_f8",    32'(w_pc),      32'hF8);
      check("t5_instr_f8", w_instr,        32'h2000_00F8);
      tick();
      check("t1_pc4",     out_pc,       32'h4);
      check("t5_addr_04", 32'(w_addr),  32'h04);
      check("t5_pc_fc",   32'(w_pc),    32'hFC);
      tick();
      check("t1_pc8",    out_pc,    32'h8);
      check("t1_instr8", out_instr, 32'h1000_0008);
      check("t5_pc_00",  32'(w_pc), 32'h00);

      // 2: back-pressure fills exactly DEPTH, then in-order drain
      do_reset(1'b0);
      for (int i = 0; i < 10; i++) tick();
      check("t2_full_valid", 32'(out_valid), 32'h1);
      check("t2_full_req",   32'(imem_req),  32'h0);
      check("t2_full_head",  out_pc,         32'h0);
`ifdef FETCH_STATS_EN
      check("t2_fetched", stat_fetched, 32'd4);
`endif
      out_ready = 1'b1;
      #1;
      for (int k = 0; k < 6; k++) begin
         check("t2_drain_valid", 32'(out_valid), 32'h1);
         check("t2_drain_pc",    out_pc,         32'(4 * k));
         check("t2_drain_instr", out_instr,      32'h1000_0000 | 32'(4 * k));
         if (k == 1) begin
            check("t2_resume_req",  32'(imem_req), 32'h1);
            check("t2_resume_addr", imem_addr,     32'h10);
         end
         tick();
      end

      // 3: redirect with 3 buffered + 1 inflight
      do_reset(1'b0);
      for (int i = 0; i < 5; i++) tick();
      check("t3_pre_valid", 32'(out_valid), 32'h1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h103;
      #1;
      check("t3_redir_req", 32'(imem_req), 32'h0);
      tick();
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      #1;
      check("t3_flushed_valid", 32'(out_valid), 32'h0);
      check("t3_hold_pc",       out_pc,         32'h0);
      check("t3_new_req",       32'(imem_req),  32'h1);
      check("t3_new_addr",      imem_addr,      32'h100);
`ifdef FETCH_STATS_EN
      check("t3_stat_flushed", stat_flushed, 32'd4);
      check("t3_stat_fetched", stat_fetched, 32'd3);
`endif
      tick();
      check("t3_no_stale", 32'(out_valid), 32'h0);
      tick();
      check("t3_valid",  32'(out_valid), 32'h1);
      check("t3_pc100",  out_pc,         32'h100);
      check("t3_instr",  out_instr,      32'h1000_0100);
      tick();
      check("t3_pc104",  out_pc,         32'h104);

      // 4: redirect and pop in the same cycle
      do_reset(1'b0);
      for (int i = 0; i < 5; i++) tick();
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      #1;
      check("t4_valid_ungated", 32'(out_valid), 32'h1);
      check("t4_head",          out_pc,         32'h0);
      tick();
      redirect_valid = 1'b0;
      #1;
      check("t4_empty", 32'(out_valid), 32'h0);
`ifdef FETCH_STATS_EN
      check("t4_stat_flushed", stat_flushed, 32'd3);
`endif
      tick();
      check("t4_empty2", 32'(out_valid), 32'h0);
      tick();
      check("t4_valid", 32'(out_valid), 32'h1);
      check("t4_pc40",  out_pc,         32'h40);

      // 6: asynchronous reset mid-operation
      do_reset(1'b0);
      for (int i = 0; i < 4; i++) tick();
      check("t6_pre_instr", out_instr, 32'h1000_0000);
      #2;
      rst = 1'b0;
      #1;
      check("t6_rst_req",   32'(imem_req),  32'h0);
      check("t6_rst_valid", 32'(out_valid), 32'h0);
      check("t6_rst_pc",    out_pc,         32'h0);
      check("t6_rst_instr", out_instr,      32'h0);
`ifdef FETCH_STATS_EN
      check("t6_rst_fetched", stat_fetched, 32'h0);
`endif
      tick();
      rst       = 1'b1;
      out_ready = 1'b1;
      #1;
      tick();
      tick();
      check("t6_no_stale", 32'(out_valid), 32'h0);
      tick();
      check("t6_valid", 32'(out_valid), 32'h1);
      check("t6_pc",    out_pc,         32'h0);
      check("t6_instr", out_instr,      32'h1000_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
